// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Brief    : ALU operation codes and checker state encoding.
// Revision : 1.0
// ============================================================================
package alu_pkg;

    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_SUB = 2'd1;
    localparam logic [1:0] ALU_AND = 2'd2;
    localparam logic [1:0] ALU_OR  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_resp_checker_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_resp_checker_if
// Brief    : Stimulus/result bundle between the ALU side and the response checker.
// Revision : 1.0
// ============================================================================
interface alu_resp_checker_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
);
    logic             inicio;
    logic             fim;
    logic             valido;
    logic [WIDTH-1:0] entradaA;
    logic [WIDTH-1:0] entradaB;
    logic [1:0]       sel;
    logic [WIDTH-1:0] out;
    logic             ocupado;
    logic             pronto;
    logic             aprovado;
    logic [CNT_W-1:0] n_testes;
    logic [CNT_W-1:0] n_erros;
    logic [1:0]       erro_sel;
    logic [WIDTH-1:0] erro_out;
    logic [WIDTH-1:0] erro_esp;

    modport master (
        output inicio, fim, valido, entradaA, entradaB, sel, out,
        input  ocupado, pronto, aprovado, n_testes, n_erros, erro_sel, erro_out, erro_esp
    );

    modport slave (
        input  inicio, fim, valido, entradaA, entradaB, sel, out,
        output ocupado, pronto, aprovado, n_testes, n_erros, erro_sel, erro_out, erro_esp
    );
endinterface
`default_nettype wire

// File: rtl/alu_ref_model.sv
`default_nettype none
// ============================================================================
// Module   : alu_ref_model
// Brief    : Combinational golden ALU (unsigned, modulo 2^WIDTH).
// Revision : 1.0
// ============================================================================
module alu_ref_model
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [1:0]       i_sel,
    output logic [WIDTH-1:0] o_esperado
);

    always_comb begin
        o_esperado = '0;
        case (i_sel)
            ALU_ADD: o_esperado = i_a + i_b;
            ALU_SUB: o_esperado = i_a - i_b;
            ALU_AND: o_esperado = i_a & i_b;
            ALU_OR:  o_esperado = i_a | i_b;
            default: o_esperado = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_resp_checker.sv
`default_nettype none
// ============================================================================
// Module   : alu_resp_checker
// Brief    : Two-stage ALU response checker with saturating counters and
//            first-mismatch capture.
// Revision : 1.0
// ============================================================================
module alu_resp_checker
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    alu_resp_checker_if.slave   bus
);

    localparam logic [CNT_W-1:0] c_cnt_max = '1;
    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_state_nxt;

    logic             r_s1_vld;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;
    logic [1:0]       r_s1_sel;
    logic [WIDTH-1:0] r_s1_out;

    logic             r_s2_vld;
    logic [1:0]       r_s2_sel;
    logic [WIDTH-1:0] r_s2_out;
    logic [WIDTH-1:0] r_s2_esp;

    logic [WIDTH-1:0] w_esp;
    logic             w_clear;
    logic             w_sample;
    logic             w_mismatch;
    logic             w_capture;
    logic [CNT_W-1:0] w_testes_nxt;
    logic [CNT_W-1:0] w_erros_nxt;

    logic [CNT_W-1:0] r_n_testes;
    logic [CNT_W-1:0] r_n_erros;
    logic [1:0]       r_erro_sel;
    logic [WIDTH-1:0] r_erro_out;
    logic [WIDTH-1:0] r_erro_esp;
    logic             r_pronto;
    logic             r_aprovado;

    // inicio restarts from any state and takes priority over fim and valido.
    assign w_clear  = bus.inicio;
    assign w_sample = bus.valido && (r_state == ST_RUN) && !bus.inicio;

    alu_ref_model #(
        .WIDTH (WIDTH)
    ) u_ref (
        .i_a        (r_s1_a),
        .i_b        (r_s1_b),
        .i_sel      (r_s1_sel),
        .o_esperado (w_esp)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // S1 never loads outside RUN, so once it is empty S2 drains on the same edge.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.inicio) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (bus.inicio)   w_state_nxt = ST_RUN;
                else if (bus.fim) w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (bus.inicio)     w_state_nxt = ST_RUN;
                else if (!r_s1_vld) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                if (bus.inicio) w_state_nxt = ST_RUN;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_vld <= 1'b0;
            r_s1_a   <= '0;
            r_s1_b   <= '0;
            r_s1_sel <= '0;
            r_s1_out <= '0;
            r_s2_vld <= 1'b0;
            r_s2_sel <= '0;
            r_s2_out <= '0;
            r_s2_esp <= '0;
        end else if (w_clear) begin
            r_s1_vld <= 1'b0;
            r_s2_vld <= 1'b0;
        end else begin
            r_s1_vld <= w_sample;
            if (w_sample) begin
                r_s1_a   <= bus.entradaA;
                r_s1_b   <= bus.entradaB;
                r_s1_sel <= bus.sel;
                r_s1_out <= bus.out;
            end
            r_s2_vld <= r_s1_vld;
            if (r_s1_vld) begin
                r_s2_sel <= r_s1_sel;
                r_s2_out <= r_s1_out;
                r_s2_esp <= w_esp;
            end
        end
    end

    always_comb begin
        w_mismatch   = r_s2_vld && (r_s2_out != r_s2_esp);
        w_capture    = 1'b0;
        w_testes_nxt = r_n_testes;
        w_erros_nxt  = r_n_erros;
        if (w_clear) begin
            w_testes_nxt = '0;
            w_erros_nxt  = '0;
        end else if (r_s2_vld) begin
            if (r_n_testes != c_cnt_max) w_testes_nxt = r_n_testes + c_cnt_one;
            if (w_mismatch) begin
                if (r_n_erros != c_cnt_max) w_erros_nxt = r_n_erros + c_cnt_one;
                w_capture = (r_n_erros == '0);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_n_testes <= '0;
            r_n_erros  <= '0;
            r_erro_sel <= '0;
            r_erro_out <= '0;
            r_erro_esp <= '0;
            r_pronto   <= 1'b0;
            r_aprovado <= 1'b0;
        end else begin
            r_n_testes <= w_testes_nxt;
            r_n_erros  <= w_erros_nxt;
            if (w_clear) begin
                r_erro_sel <= '0;
                r_erro_out <= '0;
                r_erro_esp <= '0;
            end else if (w_capture) begin
                r_erro_sel <= r_s2_sel;
                r_erro_out <= r_s2_out;
                r_erro_esp <= r_s2_esp;
            end
            r_pronto   <= (w_state_nxt == ST_DONE);
            r_aprovado <= (w_state_nxt == ST_DONE) && (w_erros_nxt == '0);
        end
    end

    assign bus.ocupado  = (r_state == ST_RUN) || (r_state == ST_DRAIN);
    assign bus.pronto   = r_pronto;
    assign bus.aprovado = r_aprovado;
    assign bus.n_testes = r_n_testes;
    assign bus.n_erros  = r_n_erros;
    assign bus.erro_sel = r_erro_sel;
    assign bus.erro_out = r_erro_out;
    assign bus.erro_esp = r_erro_esp;

endmodule
`default_nettype wire
